// File: rtl/fifo_read_stage.sv
`default_nettype none
// ============================================================================
// Module   : fifo_read_stage
// Purpose  : Read-side stage for a show-ahead FIFO. Pops words from the
//            upstream FIFO into a 2-entry in-order skid buffer and presents
//            them downstream with a valid/ready handshake. It also checks
//            every popped word against an incrementing sequence.
// Ports    :
//   clk           rising-edge clock
//   reset         asynchronous active-high reset
//   fifo_empty    upstream FIFO empty flag; fifo_data is valid when 0
//   fifo_data     upstream FIFO head word (show-ahead)
//   fifo_read     pop strobe to the upstream FIFO (combinational)
//   out_valid     downstream data valid
//   out_data      downstream data word (oldest buffered entry)
//   out_ready     downstream accept
//   seq_check_en  enables sequence checking of popped words
//   seq_err       one-cycle pulse after a popped word breaks the sequence
//   err_count     saturating count of sequence mismatches
//   pop_count     saturating count of words popped from the upstream FIFO
// Revision : 1.0  initial release
// ============================================================================
module fifo_read_stage #(
  parameter int DATA_BITS = 11,
  parameter int CNT_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_data,
  output logic                 fifo_read,
  output logic                 out_valid,
  output logic [DATA_BITS-1:0] out_data,
  input  logic                 out_ready,
  input  logic                 seq_check_en,
  output logic                 seq_err,
  output logic [CNT_BITS-1:0]  err_count,
  output logic [CNT_BITS-1:0]  pop_count
);

  // Buffer occupancy states
  localparam logic [1:0] c_EMPTY = 2'd0;
  localparam logic [1:0] c_ONE   = 2'd1;
  localparam logic [1:0] c_TWO   = 2'd2;

  localparam logic [CNT_BITS-1:0]  c_CNT_MAX = {CNT_BITS{1'b1}};
  localparam logic [CNT_BITS-1:0]  c_CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};
  localparam logic [DATA_BITS-1:0] c_DAT_ONE = {{(DATA_BITS-1){1'b0}}, 1'b1};

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_mismatch;
  logic [DATA_BITS-1:0] r_buf0;      // oldest entry, drives out_data
  logic [DATA_BITS-1:0] r_buf1;      // second entry, valid only in TWO
  logic [DATA_BITS-1:0] r_exp;
  logic                 r_seq_err;
  logic [CNT_BITS-1:0]  r_err_count;
  logic [CNT_BITS-1:0]  r_pop_count;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_EMPTY: if (w_push) w_state_nxt = c_ONE;
      c_ONE: begin
        if (w_push && !w_pop)      w_state_nxt = c_TWO;
        else if (w_pop && !w_push) w_state_nxt = c_EMPTY;
      end
      c_TWO:   if (w_pop) w_state_nxt = c_ONE;
      default: w_state_nxt = c_EMPTY;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic. fifo_read is gated by reset so the upstream FIFO is never
  // popped while the stage is being cleared.
  // --------------------------------------------------------------------------
  always_comb begin
    fifo_read = !reset && !fifo_empty && (r_state != c_TWO);
    out_valid = (r_state != c_EMPTY);
  end

  assign w_push     = fifo_read;
  assign w_pop      = out_valid && out_ready;
  assign w_mismatch = w_push && seq_check_en && (fifo_data != r_exp);

  // --------------------------------------------------------------------------
  // Buffer storage. A pop in TWO shifts the second entry into the head slot;
  // a simultaneous push/pop in ONE replaces the head directly.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_buf0 <= '0;
      r_buf1 <= '0;
    end else begin
      case (r_state)
        c_EMPTY: if (w_push) r_buf0 <= fifo_data;
        c_ONE: begin
          if (w_push && w_pop) r_buf0 <= fifo_data;
          else if (w_push)     r_buf1 <= fifo_data;
        end
        c_TWO:   if (w_pop) r_buf0 <= r_buf1;
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Sequence checker and counters. exp always resynchronises to the word
  // just popped so a single gap produces a single error.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_exp       <= '0;
      r_seq_err   <= 1'b0;
      r_err_count <= '0;
      r_pop_count <= '0;
    end else begin
      r_seq_err <= w_mismatch;
      if (w_push) begin
        r_exp <= fifo_data + c_DAT_ONE;
        if (r_pop_count != c_CNT_MAX) r_pop_count <= r_pop_count + c_CNT_ONE;
      end
      if (w_mismatch && (r_err_count != c_CNT_MAX)) begin
        r_err_count <= r_err_count + c_CNT_ONE;
      end
    end
  end

  assign out_data  = r_buf0;
  assign seq_err   = r_seq_err;
  assign err_count = r_err_count;
  assign pop_count = r_pop_count;

endmodule
`default_nettype wire

// File: tb/tb_fifo_read_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_read_stage
// Purpose  : Self-checking bench for fifo_read_stage. The upstream FIFO and
//            the stage are modelled as queues; expected handshakes, data
//            order, sequence errors and counters come from that model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fifo_read_stage;

  localparam int DW   = 11;
  localparam int CW   = 4;      // small counters so saturation is reachable
  localparam int DMOD = 2048;
  localparam int CMAX = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic          out_ready = 1'b0;
  logic          seq_check_en = 1'b0;
  logic          fifo_read;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          seq_err;
  logic [CW-1:0] err_count;
  logic [CW-1:0] pop_count;

  int checks = 0;
  int errors = 0;

  int src[$];     // upstream FIFO contents
  int q[$];       // words held by the stage, oldest first
  int m_exp;
  int m_err;
  int m_pop;
  bit m_seq_err;
  int rd_high;

  fifo_read_stage #(.DATA_BITS(DW), .CNT_BITS(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .fifo_empty   (fifo_empty),
    .fifo_data    (fifo_data),
    .fifo_read    (fifo_read),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .seq_check_en (seq_check_en),
    .seq_err      (seq_err),
    .err_count    (err_count),
    .pop_count    (pop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_exp = 0;
    m_err = 0;
    m_pop = 0;
    m_seq_err = 1'b0;
  endtask

  // One clock cycle: drive at the falling edge, check, then advance the model
  // across the rising edge.
  task automatic step(input bit stall, input bit rdy, input bit en);
    bit efr;
    fifo_empty   = (src.size() == 0) || stall;
    fifo_data    = fifo_empty ? DW'($urandom) : DW'(src[0]);
    out_ready    = rdy;
    seq_check_en = en;
    #1;
    efr = !fifo_empty && (q.size() < 2);
    if (fifo_read) rd_high++;
    check("fifo_read", 32'(fifo_read), 32'(efr));
    check("out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) check("out_data", 32'(out_data), 32'(q[0]));
    check("seq_err", 32'(seq_err), 32'(m_seq_err));
    check("err_count", 32'(err_count), 32'(m_err));
    check("pop_count", 32'(pop_count), 32'(m_pop));
    @(posedge clk);
    m_seq_err = 1'b0;
    if (q.size() > 0 && rdy) void'(q.pop_front());
    if (efr) begin
      int d;
      d = src.pop_front();
      q.push_back(d);
      if (en && d != m_exp) begin
        m_seq_err = 1'b1;
        if (m_err < CMAX) m_err++;
      end
      if (m_pop < CMAX) m_pop++;
      m_exp = (d + 1) % DMOD;
    end
    @(negedge clk);
  endtask

  // Reset applied at a falling edge; outputs must clear before any rising edge.
  task automatic do_reset();
    reset      = 1'b1;
    fifo_empty = 1'b0;
    model_reset();
    #1;
    check("rst_fifo_read", 32'(fifo_read), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_seq_err", 32'(seq_err), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_pop_count", 32'(pop_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    do_reset();

    // Streaming 0..9 at full rate
    src.delete();
    for (int i = 0; i < 10; i++) src.push_back(i);
    for (int i = 0; i < 13; i++) step(1'b0, 1'b1, 1'b1);
    check("stream_pop_count", 32'(pop_count), 32'd10);
    check("stream_err_count", 32'(err_count), 32'd0);

    // Backpressure: only two pops while the output is stalled
    do_reset();
    src.delete();
    for (int i = 0; i < 6; i++) src.push_back(i);
    rd_high = 0;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1);
    check("bp_reads", 32'(rd_high), 32'd2);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1);
    check("bp_pop_count", 32'(pop_count), 32'd6);

    // Mismatch: single error at the jump to 7
    do_reset();
    src = '{0, 1, 2, 7, 8};
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1);
    check("mm_err_count", 32'(err_count), 32'd1);

    // Wrap: error only on the first word, none across 2047 -> 0
    do_reset();
    src = '{2046, 2047, 0, 1};
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b1);
    check("wrap_err_count", 32'(err_count), 32'd1);

    // Reset while holding two words
    do_reset();
    src.delete();
    for (int i = 0; i < 6; i++) src.push_back(i);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
    check("pre_rst_full", 32'(out_valid && !fifo_read), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_fifo_read", 32'(fifo_read), 32'd0);
    check("mid_rst_pop_count", 32'(pop_count), 32'd0);
    check("mid_rst_err_count", 32'(err_count), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    src = '{0, 1};
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1);
    check("post_rst_err_count", 32'(err_count), 32'd0);
    check("post_rst_pop_count", 32'(pop_count), 32'd2);

    // Randomised traffic with occasional sequence gaps
    do_reset();
    src.delete();
    begin
      int v;
      v = 0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(7) == 0) v = int'($urandom_range(DMOD - 1));
        src.push_back(v);
        v = (v + 1) % DMOD;
      end
    end
    for (int i = 0; i < 2500; i++) begin
      step($urandom_range(3) == 0, $urandom_range(2) != 0, $urandom_range(3) != 0);
    end
    check("rand_pop_sat", 32'(pop_count), 32'(CMAX));
    check("rand_err_sat", 32'(err_count), 32'(CMAX));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
